mult_rr_seq: RTL and testbench

- Sequential shift-and-add multiplier shared by two requesters through a round-robin arbiter.
- One unsigned W x W multiply is in flight at a time; a result takes W cycles of computation.
- Sits beside the combinational 4x4 multiplier as the area-lean, shared alternative. Downstream logic sees one result bus tagged with the winning requester ID.

---
 rtl/mult_rr_seq_if.sv | 29 ++
 rtl/mult_rr_seq.sv | 116 +++++++++++
 tb/tb_mult_rr_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mult_rr_seq_if.sv
// Request/grant/result bundle shared between two requesters and the
// shared shift-and-add multiplier. The master side drives requests and
// operands; the slave side (the multiplier) returns grants and results.
interface mult_rr_seq_if #(
  parameter int W = 4
);
  logic           req0;
  logic [W-1:0]   A0;
  logic [W-1:0]   B0;
  logic           req1;
  logic [W-1:0]   A1;
  logic [W-1:0]   B1;
  logic           gnt0;
  logic           gnt1;
  logic           busy;
  logic [2*W-1:0] P;
  logic           done;
  logic           done_id;

  modport master (
    output req0, A0, B0, req1, A1, B1,
    input  gnt0, gnt1, busy, P, done, done_id
  );

  modport slave (
    input  req0, A0, B0, req1, A1, B1,
    output gnt0, gnt1, busy, P, done, done_id
  );
endinterface

// File: rtl/mult_rr_seq.sv
// Shared sequential shift-and-add multiplier. Two requesters compete
// through a round-robin arbiter; one unsigned W x W multiply runs at a
// time and takes W cycles, followed by a one-cycle done pulse carrying
// the product and the ID of the requester that owns it.
module mult_rr_seq #(
  parameter int W = 4
) (
  input logic          clk,
  input logic          rst,
  mult_rr_seq_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_mcand;
  logic [W-1:0]   r_mplr;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_id;
  logic           r_lastId;
  logic [2*W-1:0] r_p;
  logic           r_doneId;
  logic           r_busy;
  logic           r_done;

  logic           w_inIdle;
  logic           w_anyReq;
  logic           w_pick1;
  logic [W-1:0]   w_opA;
  logic [W-1:0]   w_opB;
  logic [2*W-1:0] w_addend;
  logic [2*W-1:0] w_accNext;

  // Arbitration: a lone requester wins outright; on a tie the requester
  // that did not win last time goes next. Grants are only offered in IDLE.
  assign w_inIdle = (r_state == IDLE);
  assign w_anyReq = bus.req0 | bus.req1;
  assign w_pick1  = bus.req1 & (~bus.req0 | ~r_lastId);
  assign w_opA    = w_pick1 ? bus.A1 : bus.A0;
  assign w_opB    = w_pick1 ? bus.B1 : bus.B0;

  // One partial product per cycle: the multiplicand shifted to the weight
  // of the current multiplier bit. 2W bits holds (2^W-1)^2 without loss.
  assign w_addend  = r_mplr[0] ? ({{W{1'b0}}, r_mcand} << r_cnt) : '0;
  assign w_accNext = r_acc + w_addend;

  assign bus.gnt0    = w_inIdle & bus.req0 & ~w_pick1;
  assign bus.gnt1    = w_inIdle & w_pick1;
  assign bus.busy    = r_busy;
  assign bus.P       = r_p;
  assign bus.done    = r_done;
  assign bus.done_id = r_doneId;

  // Control FSM and datapath: capture the winner's operands on the grant
  // edge, accumulate for W cycles, publish the product on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_id     <= 1'b0;
      r_lastId <= 1'b1;
      r_p      <= '0;
      r_doneId <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_anyReq) begin
            r_mcand  <= w_opA;
            r_mplr   <= w_opB;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_id     <= w_pick1;
            r_lastId <= w_pick1;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_acc  <= w_accNext;
          r_mplr <= r_mplr >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(W - 1)) begin
            r_p      <= w_accNext;
            r_doneId <= r_id;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_rr_seq.sv
// Self-checking bench for mult_rr_seq. A transaction-level model keeps
// the round-robin history, the last published product/owner and whether
// the multiplier has just finished, and predicts grants, timing and
// products with plain arithmetic.
module tb_mult_rr_seq;

  localparam int W = 4;

  logic clk;
  logic rst;

  int checks;
  int errors;

  bit             lastId;
  bit             justDone;
  logic [2*W-1:0] prevP;
  bit             prevId;

  mult_rr_seq_if #(.W(W)) bus ();

  mult_rr_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Synchronous reset with inputs quiet; checks the reset values and
  // brings the model back to its reset view.
  task automatic resetDut();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstP", 64'(bus.P), 64'(0));
    checkOutput("rstBusy", 64'(bus.busy), 64'(0));
    checkOutput("rstDone", 64'(bus.done), 64'(0));
    checkOutput("rstDoneId", 64'(bus.done_id), 64'(0));
    checkOutput("rstGnt", 64'({bus.gnt1, bus.gnt0}), 64'(0));
    lastId   = 1'b1;
    justDone = 1'b0;
    prevP    = '0;
    prevId   = 1'b0;
  endtask

  // One transaction. mode: 0 plain, 1 change winner operands mid-CALC,
  // 2 raise the other request mid-CALC, 3 reset mid-CALC.
  task automatic applyStimulus(input bit r0, input bit r1,
                               input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input int mode);
    bit             expId;
    logic [W-1:0]   ea;
    logic [W-1:0]   eb;
    logic [2*W-1:0] expP;
    int             waited;
    bit             seen;

    if (r0 && r1) expId = ~lastId;
    else          expId = r1;
    ea   = expId ? a1 : a0;
    eb   = expId ? b1 : b0;
    expP = (2*W)'(ea) * (2*W)'(eb);

    bus.req0 = r0; bus.req1 = r1;
    bus.A0 = a0; bus.B0 = b0; bus.A1 = a1; bus.B1 = b1;
    #1;
    waited = 0;
    seen   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.gnt0 || bus.gnt1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("gntSeen", 64'(seen), 64'(1));
    if (!seen) return;
    checkOutput("gntWait", 64'(waited), justDone ? 64'(1) : 64'(0));
    checkOutput("gntVec", 64'({bus.gnt1, bus.gnt0}), expId ? 64'(2) : 64'(1));
    checkOutput("pHeld", 64'(bus.P), 64'(prevP));
    checkOutput("idHeld", 64'(bus.done_id), 64'(prevId));
    lastId = expId;

    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (expId) bus.req1 = 1'b0;
        else       bus.req0 = 1'b0;
      end
      #1;
      checkOutput("busy", 64'(bus.busy), 64'(1));
      checkOutput("gntQuiet", 64'({bus.gnt1, bus.gnt0}), 64'(0));
      checkOutput("donePulse", 64'(bus.done), (k == W + 1) ? 64'(1) : 64'(0));
      if (k < W + 1) checkOutput("pCalc", 64'(bus.P), 64'(prevP));
      if (k == 2) begin
        if (mode == 1) begin
          if (expId) begin bus.A1 = ~bus.A1; bus.B1 = ~bus.B1; end
          else       begin bus.A0 = ~bus.A0; bus.B0 = ~bus.B0; end
        end else if (mode == 2) begin
          if (expId) bus.req0 = 1'b1;
          else       bus.req1 = 1'b1;
        end else if (mode == 3) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          #1;
          checkOutput("midRstBusy", 64'(bus.busy), 64'(0));
          checkOutput("midRstP", 64'(bus.P), 64'(0));
          checkOutput("midRstDone", 64'(bus.done), 64'(0));
          checkOutput("midRstId", 64'(bus.done_id), 64'(0));
          for (int q = 0; q < W + 2; q++) begin
            @(negedge clk);
            #1;
            checkOutput("noDoneAfterRst", 64'(bus.done), 64'(0));
            checkOutput("idleAfterRst", 64'(bus.busy), 64'(0));
          end
          lastId   = 1'b1;
          justDone = 1'b0;
          prevP    = '0;
          prevId   = 1'b0;
          return;
        end
      end
    end
    checkOutput("product", 64'(bus.P), 64'(expP));
    checkOutput("doneId", 64'(bus.done_id), 64'(expId));
    prevP    = expP;
    prevId   = expId;
    justDone = 1'b1;
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;

    resetDut();
    applyStimulus(1'b1, 1'b0, 4'd15, 4'd12, 4'd0, 4'd0, 0);

    resetDut();
    applyStimulus(1'b1, 1'b1, 4'd10, 4'd8, 4'd12, 4'd5, 0);
    applyStimulus(1'b1, 1'b1, 4'd10, 4'd8, 4'd12, 4'd5, 0);
    applyStimulus(1'b1, 1'b1, 4'd3, 4'd9, 4'd12, 4'd5, 0);

    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd2, 4'd4, 1);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd15, 4'd0, 4'd0, 0);
    applyStimulus(1'b1, 1'b0, 4'd15, 4'd15, 4'd0, 4'd0, 0);

    applyStimulus(1'b1, 1'b0, 4'd15, 4'd12, 4'd0, 4'd0, 3);
    applyStimulus(1'b1, 1'b1, 4'd3, 4'd5, 4'd9, 4'd7, 0);

    applyStimulus(1'b1, 1'b0, 4'd7, 4'd9, 4'd0, 4'd0, 2);
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd11, 4'd13, 0);

    for (int n = 0; n < 30; n++) begin
      bit r0;
      bit r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(r0, r1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                    int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
